// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state encoding used by rx_core and tx_core,
// default frame parameters, and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_SAMPLING_TICKS = 16;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; flops reset to RESET_VAL
// so an idle line never looks like an edge coming out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/rx_core.sv
// UART receive engine: synchronises rx, validates the start bit at mid-bit,
// shifts in WIDTH data bits LSB-first, checks stop bits and reports via valid/ack.
module rx_core
  import uart_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLING_TICKS = DEF_SAMPLING_TICKS,
  parameter int STOP_BITS      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             baud_tick,
  input  logic             rx_ack,
  output logic [WIDTH-1:0] rx_data_out,
  output logic             rx_valid,
  output logic             rx_pending,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun_err
);

  localparam int BIT_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int BIT_W   = cnt_width(BIT_MAX);
  localparam int BAUD_W  = cnt_width(SAMPLING_TICKS);

  localparam logic [BAUD_W-1:0] MID_CNT   = BAUD_W'(SAMPLING_TICKS / 2 - 1);
  localparam logic [BAUD_W-1:0] END_CNT   = BAUD_W'(SAMPLING_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  logic              rx_s;
  logic              rx_prev;
  logic              fall;
  uart_state_e       state, state_d;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0]  shift_reg, shift_reg_d;
  logic              stop_err, stop_err_d;
  logic [WIDTH-1:0]  data_d;
  logic              valid_d, pending_d, ferr_d, ovr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign fall    = rx_prev & ~rx_s;
  assign rx_busy = (state != IDLE);

  // Stage boundary: all state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev     <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      stop_err    <= 1'b0;
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
      rx_pending  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      state       <= state_d;
      baud_cnt    <= baud_cnt_d;
      bit_cnt     <= bit_cnt_d;
      shift_reg   <= shift_reg_d;
      stop_err    <= stop_err_d;
      rx_data_out <= data_d;
      rx_valid    <= valid_d;
      rx_pending  <= pending_d;
      frame_err   <= ferr_d;
      overrun_err <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state;
    baud_cnt_d  = baud_cnt;
    bit_cnt_d   = bit_cnt;
    shift_reg_d = shift_reg;
    stop_err_d  = stop_err;
    data_d      = rx_data_out;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    pending_d   = rx_pending & ~rx_ack;

    case (state)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          baud_cnt_d = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (baud_cnt == MID_CNT) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx_s) begin
              state_d    = DATA;
              baud_cnt_d = '0;
              bit_cnt_d  = '0;
              stop_err_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            baud_cnt_d = baud_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (baud_cnt == END_CNT) begin
            baud_cnt_d  = '0;
            shift_reg_d = {rx_s, shift_reg[WIDTH-1:1]};
            if (bit_cnt == LAST_DATA) begin
              state_d   = STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt_d = baud_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (baud_cnt == END_CNT) begin
            baud_cnt_d = '0;
            if (bit_cnt == LAST_STOP) begin
              // Leave at mid-stop so the next start edge is not missed.
              state_d = IDLE;
              if (stop_err || !rx_s) begin
                ferr_d = 1'b1;
              end else begin
                data_d    = shift_reg;
                valid_d   = 1'b1;
                pending_d = 1'b1;
                ovr_d     = rx_pending & ~rx_ack;
              end
            end else begin
              bit_cnt_d  = bit_cnt + 1'b1;
              stop_err_d = stop_err | ~rx_s;
            end
          end else begin
            baud_cnt_d = baud_cnt + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_core.sv
// Scoreboard bench for rx_core: frames are driven bit by bit on the baud_tick
// schedule, expected completions are queued and matched against DUT pulses.
module tb_rx_core;

  localparam int TICK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       baud_tick;
  logic       rx_ack;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_pending;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  typedef struct {
    logic       good;
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int   errors = 0;
  int   checks = 0;
  logic       model_pending = 1'b0;
  logic [7:0] model_data    = 8'h00;

  rx_core #(.WIDTH(8), .SAMPLING_TICKS(16), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .rx_ack     (rx_ack),
    .rx_data_out(rx_data_out),
    .rx_valid   (rx_valid),
    .rx_pending (rx_pending),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Returns just after the posedge that consumes the n-th baud_tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  // ack_mode: 0 none, 1 ack pulse after completion, 2 ack on the completion cycle
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int ack_mode);
    exp_t e;
    e.good = stop_v;
    e.data = d;
    e.ovr  = 1'b0;
    if (stop_v) begin
      e.ovr         = model_pending && (ack_mode != 2);
      model_pending = 1'b1;
      model_data    = d;
    end
    sb.push_back(e);

    rx = 1'b0;
    wait_ticks(16);
    chk("busy_in_frame", rx_busy, 1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop_v;
    if (ack_mode == 2) begin
      wait_ticks(7);
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
    end else begin
      wait_ticks(8);
    end
    chk("busy_after_stop", rx_busy, 0);
    chk("pending_after", rx_pending, model_pending);
    chk("data_after", rx_data_out, model_data);
    if (ack_mode == 1) begin
      @(posedge clk);
      #1 rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
      model_pending = 1'b0;
      chk("pending_acked", rx_pending, 0);
    end
    wait_ticks(8);
  endtask

  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err || overrun_err)) begin
      if (sb.size() == 0) begin
        chk("spurious_evt", {29'd0, rx_valid, frame_err, overrun_err}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("valid", rx_valid, mon_e.good);
        chk("frame_err", frame_err, !mon_e.good);
        chk("overrun", overrun_err, mon_e.ovr);
        if (mon_e.good) begin
          chk("data", rx_data_out, mon_e.data);
          chk("pending_on_valid", rx_pending, 1);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data_out, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_pending", rx_pending, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun_err, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_ticks(4);

    // Clean frame, then ack
    send_frame(8'hA5, 1'b1, 0);
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    model_pending = 1'b0;
    chk("pending_cleared", rx_pending, 0);
    wait_ticks(4);

    // Glitch: low for 4 ticks only
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(3);
    chk("glitch_busy_tick7", rx_busy, 1);
    wait_ticks(1);
    chk("glitch_idle_tick8", rx_busy, 0);
    wait_ticks(8);
    chk("glitch_data_kept", rx_data_out, 8'hA5);

    // Framing error, then break held low
    send_frame(8'h3C, 1'b0, 0);
    wait_ticks(40);
    chk("break_idle", rx_busy, 0);
    chk("ferr_data_kept", rx_data_out, 8'hA5);
    rx = 1'b1;
    wait_ticks(20);

    // Back-to-back with ack after each
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    rx = 1'b1;
    wait_ticks(8);

    // Overrun, then ack coinciding with completion
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 2);
    rx = 1'b1;
    wait_ticks(8);
    chk("pending_after_coincident_ack", rx_pending, 1);

    // Reset in the middle of DATA of 0x5A
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      wait_ticks(16);
    end
    wait_ticks(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", rx_data_out, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_pending", rx_pending, 0);
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun_err, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_pending = 1'b0;
    model_data    = 8'h00;
    wait_ticks(20);

    send_frame(8'h81, 1'b1, 1);
    wait_ticks(16);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
